// File: rtl/reload_timer.sv
// reload_timer: loadable up/down timer with prescaler, one-shot or periodic
// auto-reload, and a registered one-cycle terminal-count pulse.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        count enable; low freezes both count and prescaler
//   load_en   load/arm strobe, wins over everything else
//   load_val  reload value (0 disarms the timer into IDLE)
//   mode      captured at load: 0 one-shot, 1 periodic
//   dir       captured at load: 0 count down to 0, 1 count up to load_val
//   prescale  one step every prescale+1 enabled cycles (live value)
//   count     current count, registered
//   tc        one-cycle terminal-count pulse, registered
//   running   high while the timer is in RUN, registered
module reload_timer #(
   parameter int WIDTH         = 9,
   parameter int PRESCALE_BITS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     load_en,
   input  logic [WIDTH-1:0]         load_val,
   input  logic                     mode,
   input  logic                     dir,
   input  logic [PRESCALE_BITS-1:0] prescale,
   output logic [WIDTH-1:0]         count,
   output logic                     tc,
   output logic                     running
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state_q,   state_d;
   logic [WIDTH-1:0]         count_q,   count_d;
   logic [WIDTH-1:0]         reload_q,  reload_d;
   logic                     mode_q,    mode_d;
   logic                     dir_q,     dir_d;
   logic [PRESCALE_BITS-1:0] presc_q,   presc_d;
   logic                     tc_q,      tc_d;
   logic                     running_q, running_d;

   logic [WIDTH-1:0]         term;
   logic [WIDTH-1:0]         next_count;

   // Down counts finish at 0, up counts finish at the reload value.
   assign term       = dir_q ? reload_q : '0;
   assign next_count = dir_q ? count_q + 1'b1 : count_q - 1'b1;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      dir_d    = dir_q;
      presc_d  = presc_q;
      tc_d     = 1'b0;

      if (load_en) begin
         reload_d = load_val;
         mode_d   = mode;
         dir_d    = dir;
         presc_d  = '0;
         count_d  = dir ? '0 : load_val;
         state_d  = (load_val == '0) ? IDLE : RUN;
      end else if (state_q == RUN && en) begin
         // >= rather than == so that lowering prescale mid-run steps at once
         if (presc_q >= prescale) begin
            presc_d = '0;
            if (count_q == term) begin
               // Only a periodic timer can sit at terminal while in RUN:
               // this step reloads instead of counting, silently.
               count_d = dir_q ? '0 : reload_q;
            end else begin
               count_d = next_count;
               if (next_count == term) begin
                  tc_d = 1'b1;
                  if (!mode_q) begin
                     state_d = DONE;
                  end
               end
            end
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end

      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         count_q   <= '0;
         reload_q  <= '0;
         mode_q    <= 1'b0;
         dir_q     <= 1'b0;
         presc_q   <= '0;
         tc_q      <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         mode_q    <= mode_d;
         dir_q     <= dir_d;
         presc_q   <= presc_d;
         tc_q      <= tc_d;
         running_q <= running_d;
      end
   end

   assign count   = count_q;
   assign tc      = tc_q;
   assign running = running_q;

endmodule

// File: tb/tb_reload_timer.sv
// Testbench for reload_timer: fixed vector table, directed corner-case
// sequences, then randomized stimulus against a position-based reference model.
module tb_reload_timer;

   localparam int WIDTH = 9;
   localparam int PB    = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             load_en;
   logic [WIDTH-1:0] load_val;
   logic             mode;
   logic             dir;
   logic [PB-1:0]    prescale;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             running;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reload_timer #(.WIDTH(WIDTH), .PRESCALE_BITS(PB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .load_en  (load_en),
      .load_val (load_val),
      .mode     (mode),
      .dir      (dir),
      .prescale (prescale),
      .count    (count),
      .tc       (tc),
      .running  (running)
   );

   typedef struct {
      logic             le;
      logic [WIDTH-1:0] lv;
      logic             md;
      logic             dr;
      logic [PB-1:0]    ps;
      logic             en;
      logic [WIDTH-1:0] ec;
      logic             etc;
      logic             erun;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic le, input int lv, input logic md,
                               input logic dr, input int ps, input logic e,
                               input int ec, input logic etc, input logic erun);
      vec_t v;
      v.le = le; v.lv = WIDTH'(lv); v.md = md; v.dr = dr; v.ps = PB'(ps);
      v.en = e; v.ec = WIDTH'(ec); v.etc = etc; v.erun = erun;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int val, input logic md, input logic dr, input int ps);
      load_en  = 1'b1;
      load_val = WIDTH'(val);
      mode     = md;
      dir      = dr;
      prescale = PB'(ps);
      en       = 1'b1;
      cyc();
      load_en  = 1'b0;
   endtask

   // Reference model: the timer walks a position 0..R through one period.
   // Shown count is the position itself when counting up, R minus it when down.
   int m_r, m_pos, m_wait;
   bit m_up, m_periodic, m_active, m_tc;

   function automatic int m_count();
      return m_up ? m_pos : (m_r - m_pos);
   endfunction

   task automatic model_reset();
      m_r = 0; m_pos = 0; m_wait = 0;
      m_up = 0; m_periodic = 0; m_active = 0; m_tc = 0;
   endtask

   task automatic model_tick(input bit le, input int lv, input bit md, input bit dr,
                             input int ps, input bit e);
      m_tc = 0;
      if (le) begin
         m_r = lv; m_up = dr; m_periodic = md;
         m_pos = 0; m_wait = 0; m_active = (lv != 0);
      end else if (m_active && e) begin
         if (m_wait >= ps) begin
            m_wait = 0;
            if (m_pos == m_r) begin
               m_pos = 0;
            end else begin
               m_pos++;
               if (m_pos == m_r) begin
                  m_tc = 1;
                  if (!m_periodic) m_active = 0;
               end
            end
         end else begin
            m_wait++;
         end
      end
   endtask

   initial begin
      int n;
      int tcs;
      int k;
      bit rle, rmd, rdr, ren;
      int rlv, rps;

      rst_n = 1'b0; en = 1'b0; load_en = 1'b0; load_val = '0;
      mode = 1'b0; dir = 1'b0; prescale = '0;
      #1;
      chk("reset_count", int'(count), 0);
      chk("reset_tc", int'(tc), 0);
      chk("reset_running", int'(running), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Down one-shot 5, prescale 0
      vecs.push_back(mk(1, 5, 0, 0, 0, 1, 5, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 4, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
      for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      // Down one-shot 10: freeze at 6, then reload 2 colliding with a step at 4
      vecs.push_back(mk(1, 10, 0, 0, 0, 1, 10, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 9, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 6, 0, 1));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 6, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 5, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 4, 0, 1));
      vecs.push_back(mk(1, 2, 0, 0, 0, 1, 2, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));

      foreach (vecs[i]) begin
         load_en  = vecs[i].le;
         load_val = vecs[i].lv;
         mode     = vecs[i].md;
         dir      = vecs[i].dr;
         prescale = vecs[i].ps;
         en       = vecs[i].en;
         cyc();
         chk($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].ec));
         chk($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].etc));
         chk($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].erun));
      end
      load_en = 1'b0;

      // Up periodic 3, prescale 2: count = (k/3)%4, tc when k%12==9
      do_load(3, 1, 1, 2);
      for (k = 0; k < 52; k++) begin
         chk($sformatf("per_k%0d_count", k), int'(count), (k / 3) % 4);
         chk($sformatf("per_k%0d_tc", k), int'(tc), (k % 12 == 9) ? 1 : 0);
         cyc();
      end

      // Async reset mid-run at count 7
      do_load(20, 0, 0, 0);
      repeat (13) cyc();
      chk("arst_pre_count", int'(count), 7);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_tc", int'(tc), 0);
      chk("arst_running", int'(running), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tcs = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         tcs += int'(tc);
         chk("arst_after_count", int'(count), 0);
      end
      chk("arst_after_tcs", tcs, 0);

      // load_val = 0 stays idle
      do_load(0, 1, 0, 0);
      chk("zero_running", int'(running), 0);
      chk("zero_count", int'(count), 0);
      tcs = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         tcs += int'(tc) + int'(running);
      end
      chk("zero_tcs", tcs, 0);

      // Full-range down one-shot
      do_load(511, 0, 0, 0);
      chk("max_start", int'(count), 511);
      n = 0;
      while (!tc && n < 600) begin
         cyc();
         n++;
      end
      chk("max_cycles", n, 511);
      chk("max_end_count", int'(count), 0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("max_hold_count", int'(count), 0);
         chk("max_hold_tc", int'(tc), 0);
      end

      // Prescale lowered from 7 to 1 while presc_cnt = 5
      do_load(100, 0, 0, 7);
      repeat (5) cyc();
      chk("ps_hold", int'(count), 100);
      prescale = 4'd1;
      cyc(); chk("ps_step1", int'(count), 99);
      cyc(); chk("ps_wait1", int'(count), 99);
      cyc(); chk("ps_step2", int'(count), 98);
      cyc(); chk("ps_wait2", int'(count), 98);
      cyc(); chk("ps_step3", int'(count), 97);

      // Randomized run against the reference model
      @(negedge clk);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      model_reset();
      rps = 0;
      for (int i = 0; i < 3000; i++) begin
         rle = ($urandom_range(0, 19) == 0);
         rlv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 511))
                                           : int'($urandom_range(0, 12));
         rmd = 1'($urandom_range(0, 1));
         rdr = 1'($urandom_range(0, 1));
         ren = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 9) == 0) rps = int'($urandom_range(0, 3));
         load_en = rle; load_val = WIDTH'(rlv); mode = rmd; dir = rdr;
         en = ren; prescale = PB'(rps);
         model_tick(rle, rlv, rmd, rdr, rps, ren);
         cyc();
         chk($sformatf("rnd%0d_count", i), int'(count), m_count());
         chk($sformatf("rnd%0d_tc", i), int'(tc), int'(m_tc));
         chk($sformatf("rnd%0d_running", i), int'(running), int'(m_active));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reload_timer.md
Name: reload_timer

Overview:
- Parametrised loadable timer: the next-generation replacement for the fixed down counters that pace obstacle spawn and scroll timing.
- Adds up/down direction, one-shot or periodic auto-reload, a clock prescaler, a count enable and a registered terminal-count pulse.
- Sits between the game-control FSM, which loads intervals, and the obstacle/scroll logic, which consumes `tc`.

Parameters:
WIDTH  9  counter and reload value width
PRESCALE_BITS  4  width of prescale divider select

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable; 0 freezes count and prescaler
load_en  input  1  load/arm strobe, highest priority
load_val  input  WIDTH  reload value
mode  input  1  sampled at load: 0 one-shot, 1 periodic
dir  input  1  sampled at load: 0 down, 1 up
prescale  input  PRESCALE_BITS  one step every prescale+1 enabled cycles (live value)
count  output  WIDTH  current count, registered
tc  output  1  one-cycle terminal-count pulse, registered
running  output  1  high while state is RUN

Behaviour:
- Reset (async, rst_n=0):
  - count=0, reload_reg=0, mode_reg=0, dir_reg=0, presc_cnt=0, tc=0.
  - State is IDLE, so running=0.
  - Reset asserted mid-run aborts immediately; no tc is emitted.
- States are IDLE, RUN and DONE; running = (state==RUN).
- Terminal value: 0 when dir_reg=0; reload_reg when dir_reg=1.
- load_en=1, any state, regardless of en:
  - Next cycle: reload_reg=load_val, mode_reg=mode, dir_reg=dir, presc_cnt=0, tc=0.
  - count = load_val if dir=0, otherwise 0.
  - State becomes RUN, except load_val=0, which goes to IDLE (count=0, no tc).
  - A load during RUN restarts the timer.
  - Load beats a coincident step; the step is discarded and no tc fires.
- Prescaler:
  - Active only in RUN with en=1 and load_en=0.
  - If presc_cnt >= prescale: presc_cnt<=0 and a step occurs this cycle. Otherwise presc_cnt<=presc_cnt+1.
  - Using >= makes lowering prescale mid-run take effect immediately.
  - prescale=0 steps every enabled cycle.
- Step:
  - Down: count<=count-1. Up: count<=count+1.
  - If the new count equals the terminal value, tc<=1 for exactly one cycle, aligned with count showing the terminal value.
- After reaching terminal:
  - One-shot (mode_reg=0): state moves to DONE in the same edge as tc; count holds the terminal value; no further steps.
  - Periodic (mode_reg=1): state stays RUN; the next step reloads instead of counting (down: count<=reload_reg; up: count<=0), with no tc on the reload step.
  - Periodic tc period = (reload_reg+1)*(prescale+1) enabled cycles.
- en=0 freezes count and presc_cnt. tc is never asserted while en=0, except for a pulse already registered.
- Width:
  - Arithmetic is modulo 2^WIDTH, but the terminal check prevents wrap.
  - Up count never exceeds reload_reg; down count never underflows below 0.
  - load_val = 2^WIDTH-1 is legal.
- In DONE or IDLE, count and tc are static until the next load or reset.
- Single clock domain; all outputs come directly from flops, with no combinational paths from inputs to outputs.

Test Plan:
- Reset, then load_val=5, dir=0, mode=0, prescale=0, en=1: count reads 5,4,3,2,1,0 on consecutive cycles. tc is high only in the cycle count=0. running drops in that same cycle. count stays 0 for 10 further cycles.
- load_val=3, dir=1, mode=1, prescale=2: count steps every 3 cycles through 0,1,2,3,0,1,... tc pulses when count=3, every 12 cycles, over 4 periods.
- Down one-shot load_val=10, prescale=0: drop en for 4 cycles at count=6, and count holds 6. Then assert load_en with load_val=2 at count=4, coincident with a step. Next cycle count=2 and tc=0; tc fires 2 cycles later.
- Assert rst_n=0 asynchronously mid-run at count=7, between clock edges. Outputs clear immediately to count=0, tc=0, running=0, and no pulse follows reset release.
- Boundaries with WIDTH=9:
  - load_val=0: state IDLE, running=0, no tc ever.
  - load_val=511 down one-shot, prescale=0: tc exactly 511 cycles after load, with no wrap to 511.
- Change prescale from 7 to 1 while presc_cnt=5: a step occurs on the next enabled cycle, after which the step interval is 2 cycles.
